// File: rtl/muldiv_unit_pkg.sv
// Shared types for the iterative RV32M multiply/divide unit.
// Holds the funct3 op encodings, the FSM state type and the counter sizing helper.
package muldiv_unit_pkg;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b000_0001;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } muldiv_state_e;

  function automatic int unsigned muldiv_cnt_width(input int unsigned xlen);
    return $clog2(xlen) + 1;
  endfunction

endpackage

// File: rtl/muldiv_operand_prep.sv
// Operand conditioning for muldiv_unit: magnitudes, result sign flags and
// detection of the divide-by-zero / signed-overflow fast path.
module muldiv_operand_prep
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  muldiv_op_e        op,
  input  logic [XLEN-1:0]   operand_a,
  input  logic [XLEN-1:0]   operand_b,
  output logic [XLEN-1:0]   abs_a,
  output logic [XLEN-1:0]   abs_b,
  output logic              neg_result,
  output logic              neg_rem,
  output logic              fast,
  output logic [XLEN-1:0]   fast_result
);

  logic signed_a;
  logic signed_b;
  logic sign_a;
  logic sign_b;
  logic b_zero;
  logic overflow;

  always_comb begin
    signed_a    = op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    signed_b    = op inside {OP_MULH, OP_DIV, OP_REM};
    sign_a      = signed_a & operand_a[XLEN-1];
    sign_b      = signed_b & operand_b[XLEN-1];
    abs_a       = sign_a ? -operand_a : operand_a;
    abs_b       = sign_b ? -operand_b : operand_b;
    neg_result  = sign_a ^ sign_b;
    neg_rem     = sign_a;

    b_zero      = (operand_b == '0);
    overflow    = (op == OP_DIV || op == OP_REM) &&
                  (operand_a == {1'b1, {(XLEN-1){1'b0}}}) && (operand_b == '1);
    fast        = op[2] && (b_zero || overflow);

    // op[1] separates REM/REMU from DIV/DIVU
    fast_result = '0;
    if (b_zero) begin
      fast_result = op[1] ? operand_a : '1;
    end else if (overflow) begin
      fast_result = op[1] ? '0 : operand_a;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one radix-2 step per cycle, with a 1-cycle fast path for div-by-zero/overflow.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned TAG_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 flush,
  input  logic [2:0]           op,
  input  logic [XLEN-1:0]      operand_a,
  input  logic [XLEN-1:0]      operand_b,
  input  logic [TAG_WIDTH-1:0] tag_in,
  output logic                 busy,
  output logic                 valid,
  output logic [XLEN-1:0]      result,
  output logic [TAG_WIDTH-1:0] tag_out
);

  localparam int unsigned CW = muldiv_cnt_width(XLEN);

  muldiv_state_e        state;
  muldiv_op_e           op_q;
  logic [TAG_WIDTH-1:0] tag_q;
  logic                 neg_q;
  logic                 neg_rem_q;
  logic                 fast_q;
  logic [CW-1:0]        count;
  logic [2*XLEN-1:0]    acc;
  logic [XLEN:0]        rem;
  logic [XLEN-1:0]      opb_q;

  logic [XLEN-1:0]      p_abs_a;
  logic [XLEN-1:0]      p_abs_b;
  logic                 p_neg;
  logic                 p_neg_rem;
  logic                 p_fast;
  logic [XLEN-1:0]      p_fast_res;

  logic [XLEN:0]        mul_sum;
  logic [2*XLEN-1:0]    mul_next;
  logic [XLEN:0]        div_shift;
  logic [XLEN:0]        div_trial;
  logic [2*XLEN-1:0]    prod;
  logic [XLEN-1:0]      quot;
  logic [XLEN-1:0]      rem_fix;
  logic [XLEN-1:0]      final_res;

  muldiv_operand_prep #(
    .XLEN(XLEN)
  ) u_prep (
    .op          (muldiv_op_e'(op)),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .abs_a       (p_abs_a),
    .abs_b       (p_abs_b),
    .neg_result  (p_neg),
    .neg_rem     (p_neg_rem),
    .fast        (p_fast),
    .fast_result (p_fast_res)
  );

  assign busy  = (state != IDLE);
  assign valid = (state == DONE);

  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb_q} : '0);
    mul_next  = {mul_sum, acc[XLEN-1:1]};
    div_shift = {rem[XLEN-1:0], acc[XLEN-1]};
    div_trial = div_shift - {1'b0, opb_q};

    prod      = neg_q ? -acc : acc;
    quot      = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem_fix   = neg_rem_q ? -rem[XLEN-1:0] : rem[XLEN-1:0];

    final_res = '0;
    if (fast_q) begin
      final_res = acc[XLEN-1:0];
    end else if (op_q[2]) begin
      final_res = op_q[1] ? rem_fix : quot;
    end else begin
      final_res = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end
  end

  // Counter value XLEN is the sign-fixup slot; the fast path jumps straight to it
  // with its precomputed result parked in the low half of acc.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      op_q      <= OP_MUL;
      tag_q     <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      fast_q    <= 1'b0;
      count     <= '0;
      acc       <= '0;
      rem       <= '0;
      opb_q     <= '0;
      result    <= '0;
      tag_out   <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q      <= muldiv_op_e'(op);
            tag_q     <= tag_in;
            neg_q     <= p_neg;
            neg_rem_q <= p_neg_rem;
            fast_q    <= p_fast;
            rem       <= '0;
            state     <= CALC;
            if (p_fast) begin
              acc   <= {{XLEN{1'b0}}, p_fast_res};
              opb_q <= '0;
              count <= CW'(XLEN);
            end else if (op[2]) begin
              acc   <= {{XLEN{1'b0}}, p_abs_a};
              opb_q <= p_abs_b;
              count <= '0;
            end else begin
              acc   <= {{XLEN{1'b0}}, p_abs_b};
              opb_q <= p_abs_a;
              count <= '0;
            end
          end
        end
        CALC: begin
          if (count == CW'(XLEN)) begin
            result  <= final_res;
            tag_out <= tag_q;
            state   <= DONE;
          end else begin
            count <= count + 1'b1;
            if (op_q[2]) begin
              rem            <= div_trial[XLEN] ? div_shift : div_trial;
              acc[XLEN-1:0]  <= {acc[XLEN-2:0], ~div_trial[XLEN]};
            end else begin
              acc <= mul_next;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and lightly randomised self-checking bench for muldiv_unit.
// Expected values are hand-computed or produced by an independent reference function.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        flush;
  logic [2:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [4:0]  tag_in;
  logic        busy;
  logic        valid;
  logic [31:0] result;
  logic [4:0]  tag_out;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3,
                         DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

  muldiv_unit #(
    .XLEN      (32),
    .TAG_WIDTH (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .flush     (flush),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .tag_in    (tag_in),
    .busy      (busy),
    .valid     (valid),
    .result    (result),
    .tag_out   (tag_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Called #1 after an edge; returns #1 after the accepting edge.
  task automatic launch(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] t);
    op = o; operand_a = a; operand_b = b; tag_in = t; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!valid && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] t,
                        input logic [31:0] exp, input int lat);
    int n;
    launch(o, a, b, t);
    check({name, "_busy"}, 32'(busy), 32'd1);
    wait_valid(n);
    check({name, "_lat"}, 32'(n), 32'(lat));
    check({name, "_res"}, result, exp);
    check({name, "_tag"}, 32'(tag_out), 32'(t));
    @(posedge clk); #1;
    check({name, "_pulse"}, {30'd0, valid, busy}, 32'd0);
  endtask

  function automatic logic [31:0] ref_md(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    int ia, ib;
    logic ovf;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = {32'd0, a};           ub = {32'd0, b};
    ia = a;                    ib = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (o)
      MUL:    begin p = sa * sb; return p[31:0];  end
      MULH:   begin p = sa * sb; return p[63:32]; end
      MULHSU: begin p = sa * ub; return p[63:32]; end
      MULHU:  begin p = ua * ub; return p[63:32]; end
      DIV:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(ia / ib);
      DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      REM:    return (b == 0) ? a : ovf ? 32'd0 : 32'(ia % ib);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic random_ops(input int count);
    logic [2:0]  o;
    logic [31:0] a, b, exp, got;
    logic [4:0]  t, gt;
    int lat, fa, nv;
    bit use_flush;
    for (int i = 0; i < count; i++) begin
      o = 3'($urandom_range(0, 7));
      a = pick(); b = pick();
      t = 5'($urandom_range(0, 31));
      exp = ref_md(o, a, b);
      lat = (o[2] && (b == 0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 1 : 33;
      use_flush = ($urandom_range(0, 3) == 0);
      fa = $urandom_range(1, lat);
      nv = 0; got = '0; gt = '0;
      launch(o, a, b, t);
      for (int c = 1; c <= lat + 2; c++) begin
        flush = use_flush && (c == fa);
        @(posedge clk); #1;
        if (valid) begin
          nv++; got = result; gt = tag_out;
        end
      end
      flush = 1'b0;
      check("rnd_nvalid", 32'(nv), use_flush ? 32'd0 : 32'd1);
      if (!use_flush) begin
        check("rnd_res", got, exp);
        check("rnd_tag", 32'(gt), 32'(t));
      end
    end
  endtask

  initial begin
    int n, nv;
    logic [31:0] held;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0;
    operand_a = '0; operand_b = '0; tag_in = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_busy",   32'(busy),    32'd0);
    check("rst_valid",  32'(valid),   32'd0);
    check("rst_result", result,       32'd0);
    check("rst_tag",    32'(tag_out), 32'd0);

    run_op("mul",     MUL,    32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 33);
    run_op("mulh",    MULH,   32'h8000_0000,  32'h8000_0000, 5'd6,  32'h4000_0000, 33);
    run_op("mulhu",   MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE, 33);
    run_op("mulhsu",  MULHSU, 32'hFFFF_FFFF,  32'd2,         5'd8,  32'hFFFF_FFFF, 33);
    run_op("div",     DIV,    32'hFFFF_FFF9,  32'd2,         5'd9,  32'hFFFF_FFFD, 33);
    run_op("rem",     REM,    32'hFFFF_FFF9,  32'd2,         5'd10, 32'hFFFF_FFFF, 33);
    run_op("divu",    DIVU,   32'd100,        32'd7,         5'd11, 32'd14,        33);
    run_op("remu",    REMU,   32'd100,        32'd7,         5'd12, 32'd2,         33);
    run_op("div0",    DIV,    32'd5,          32'd0,         5'd13, 32'hFFFF_FFFF, 1);
    run_op("remu0",   REMU,   32'd5,          32'd0,         5'd14, 32'd5,         1);
    run_op("divovf",  DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1);
    run_op("removf",  REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd16, 32'd0,         1);
    run_op("divu_big",DIVU,   32'hFFFF_FFFF,  32'hFFFF_FFFE, 5'd17, 32'd1,         33);

    // start while busy: second request must vanish without trace
    launch(DIVU, 32'd100, 32'd7, 5'd3);
    repeat (5) begin @(posedge clk); #1; end
    op = MUL; operand_a = 32'd2; operand_b = 32'd3; tag_in = 5'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_valid(n);
    check("busy_ign_lat", 32'(n + 6), 32'd33);
    check("busy_ign_res", result, 32'd14);
    check("busy_ign_tag", 32'(tag_out), 32'd3);
    nv = 0;
    repeat (40) begin @(posedge clk); #1; if (valid) nv++; end
    check("busy_ign_extra", 32'(nv), 32'd0);
    check("busy_ign_idle", 32'(busy), 32'd0);

    // flush at cycle 10 of a DIV, then back-to-back start
    held = result;
    launch(DIV, 32'd1000, 32'd3, 5'd20);
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy",  32'(busy),  32'd0);
    check("flush_valid", 32'(valid), 32'd0);
    check("flush_hold",  result,     held);
    run_op("after_flush", DIVU, 32'd100, 32'd7, 5'd21, 32'd14, 33);

    // flush and start together: start dropped
    op = MUL; operand_a = 32'd3; operand_b = 32'd3; tag_in = 5'd22;
    start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("flush_start_busy", 32'(busy), 32'd0);
    nv = 0;
    repeat (36) begin @(posedge clk); #1; if (valid) nv++; end
    check("flush_start_nvalid", 32'(nv), 32'd0);

    // async reset mid-CALC
    launch(MUL, 32'd9, 32'd9, 5'd23);
    repeat (8) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    check("arst_busy",   32'(busy),    32'd0);
    check("arst_valid",  32'(valid),   32'd0);
    check("arst_result", result,       32'd0);
    check("arst_tag",    32'(tag_out), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    nv = 0;
    repeat (36) begin @(posedge clk); #1; if (valid) nv++; end
    check("arst_nvalid", 32'(nv), 32'd0);
    run_op("after_rst", MUL, 32'd9, 32'd9, 5'd24, 32'd81, 33);

    random_ops(60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
